// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM states, default formats and helpers for the hybrid FIR datapath.
package fir_pkg;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    localparam int DEF_MAX_LEN = 12;
    localparam int DEF_INT_POS = 8;
    localparam int DEF_N_TAPS  = 8;
    localparam logic signed [DEF_MAX_LEN-1:0] SAT_HI = {1'b0, {(DEF_MAX_LEN-1){1'b1}}};
    localparam logic signed [DEF_MAX_LEN-1:0] SAT_LO = {1'b1, {(DEF_MAX_LEN-1){1'b0}}};
    function automatic int acc_len(input int max_len, input int n_taps);
        return 2 * max_len + $clog2(n_taps);
    endfunction
endpackage

// File: rtl/fir_rescale_sat.sv
// fir_rescale_sat: floor-rescales an accumulator by INT_POS and saturates it to MAX_LEN.
module fir_rescale_sat
    import fir_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int INT_POS = DEF_INT_POS,
    parameter int ACC_LEN = acc_len(DEF_MAX_LEN, DEF_N_TAPS)
) (
    input  logic signed [ACC_LEN-1:0] i_acc,
    output logic signed [MAX_LEN-1:0] o_data
);
    logic signed [ACC_LEN-1:0] w_shift;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;
    assign w_shift   = i_acc >>> INT_POS;
    // In range only when every bit above the result's sign bit equals the sign.
    assign w_pos_ovf = !w_shift[ACC_LEN-1] && (|w_shift[ACC_LEN-2:MAX_LEN-1]);
    assign w_neg_ovf = w_shift[ACC_LEN-1] && !(&w_shift[ACC_LEN-2:MAX_LEN-1]);
    assign o_data    = w_pos_ovf ? {1'b0, {(MAX_LEN-1){1'b1}}} :
                       w_neg_ovf ? {1'b1, {(MAX_LEN-1){1'b0}}} : w_shift[MAX_LEN-1:0];
endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: folded single-multiplier signed FIR stage, one output per accepted sample.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int INT_POS = DEF_INT_POS,
    parameter int N_TAPS  = DEF_N_TAPS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_coef_we,
    input  logic [$clog2(N_TAPS)-1:0]  i_coef_addr,
    input  logic signed [MAX_LEN-1:0]  i_coef_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic signed [MAX_LEN-1:0]  i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic signed [MAX_LEN-1:0]  o_out_data,
    output logic                       o_busy
);
    localparam int ACC_LEN = acc_len(MAX_LEN, N_TAPS);
    localparam int AW      = $clog2(N_TAPS);

    state_t                      r_state;
    logic [AW-1:0]               r_k;
    logic signed [MAX_LEN-1:0]   r_delay [N_TAPS];
    logic signed [MAX_LEN-1:0]   r_coef  [N_TAPS];
    logic signed [ACC_LEN-1:0]   r_acc;
    logic signed [MAX_LEN-1:0]   r_out;
    logic signed [2*MAX_LEN-1:0] w_prod;
    logic signed [ACC_LEN-1:0]   w_acc_next;
    logic signed [MAX_LEN-1:0]   w_sat;

    assign w_prod     = r_delay[r_k] * r_coef[r_k];
    assign w_acc_next = r_acc + {{(ACC_LEN-2*MAX_LEN){w_prod[2*MAX_LEN-1]}}, w_prod};

    fir_rescale_sat #(.MAX_LEN(MAX_LEN), .INT_POS(INT_POS), .ACC_LEN(ACC_LEN)) u_sat (
        .i_acc  (w_acc_next),
        .o_data (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                r_delay[i] <= '0;
                r_coef[i]  <= '0;
            end
        end else begin
            // Coefficients are frozen outside IDLE; a write on the accept edge feeds this computation.
            if (r_state == IDLE && i_coef_we)
                r_coef[i_coef_addr] <= i_coef_data;
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_delay[0] <= i_in_data;
                    for (int i = 1; i < N_TAPS; i++)
                        r_delay[i] <= r_delay[i-1];
                    r_acc   <= '0;
                    r_k     <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    if (r_k == AW'(N_TAPS-1)) begin
                        r_out   <= w_sat;
                        r_state <= OUT;
                    end
                end
                OUT: if (i_out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == OUT);
    assign o_busy      = (r_state != IDLE);
    assign o_out_data  = r_out;
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed and randomized checks of fir_serial_mac against an arithmetic FIR model.
module tb_fir_serial_mac;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        coef_we = 0;
    logic [2:0]  coef_addr = 0;
    logic [11:0] coef_data = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [11:0] in_data = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [11:0] out_data;
    logic        busy;
    int          n_chk = 0;
    int          n_pass = 0;
    int          md [8];
    int          mc [8];
    logic [11:0] got;

    fir_serial_mac dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // FIR output = floor(sum(x*c) / 2^8), clamped to the 12-bit signed range
    function automatic logic [11:0] model();
        longint s = 0;
        for (int k = 0; k < 8; k++) s += longint'(md[k]) * longint'(mc[k]);
        s = s >>> 8;
        if (s > 2047) s = 2047;
        else if (s < -2048) s = -2048;
        return s[11:0];
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 8; k++) begin
            md[k] = 0;
            mc[k] = 0;
        end
    endtask

    task automatic put_coef(input int a, input logic [11:0] d);
        coef_we = 1; coef_addr = 3'(a); coef_data = d;
        @(posedge clk); #1;
        coef_we = 0;
        mc[a] = int'($signed(d));
    endtask

    task automatic all_coefs(input logic [11:0] d);
        for (int a = 0; a < 8; a++) put_coef(a, d);
    endtask

    // mode 0: plain, 1: coef[0] write on the accept edge, 2: coef[0] write mid-MAC
    task automatic run_sample(input logic [11:0] x, input int stall, input int mode,
                              input logic [11:0] wd, output logic [11:0] res);
        int cyc;
        logic [11:0] exp;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1; in_data = x;
        if (mode == 1) begin
            coef_we = 1; coef_addr = 0; coef_data = wd;
            mc[0] = int'($signed(wd));
        end
        @(posedge clk); #1;
        in_valid = 0; coef_we = 0;
        for (int k = 7; k > 0; k--) md[k] = md[k-1];
        md[0] = int'($signed(x));
        exp = model();
        chk("busy_after_accept", {busy, in_ready, out_valid}, 3'b100);
        cyc = 0;
        if (mode == 2) begin
            @(posedge clk); #1;
            coef_we = 1; coef_addr = 0; coef_data = wd;
            @(posedge clk); #1;
            coef_we = 0;
            cyc = 2;
        end
        while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("latency", cyc, 8);
        chk("out_data", out_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_hold", {out_valid, in_ready, busy, out_data}, {3'b101, exp});
        end
        res = out_data;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("after_handshake", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        clear_model();
        #12;
        chk("reset_outputs", {in_ready, out_valid, busy, out_data}, {3'b100, 12'h000});
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // impulse response: eight 1.0 outputs, then zero
        all_coefs(12'h100);
        run_sample(12'h100, 0, 0, 0, got);
        chk("impulse_0", got, 12'h100);
        for (int i = 1; i < 8; i++) begin
            run_sample(12'h000, 0, 0, 0, got);
            chk("impulse_n", got, 12'h100);
        end
        run_sample(12'h000, 0, 0, 0, got);
        chk("impulse_tail", got, 12'h000);

        // floor rounding of -0.5 LSB
        all_coefs(12'h000);
        put_coef(0, 12'h080);
        run_sample(12'hFFF, 0, 0, 0, got);
        chk("floor_const", got, 12'hFFF);

        // saturation both ways
        all_coefs(12'h7FF);
        for (int i = 0; i < 8; i++) run_sample(12'h7FF, 0, 0, 0, got);
        chk("sat_pos", got, 12'h7FF);
        for (int i = 0; i < 8; i++) run_sample(12'h800, 0, 0, 0, got);
        chk("sat_neg", got, 12'h800);

        // backpressure
        all_coefs(12'h040);
        run_sample(12'h3A5, 5, 0, 0, got);

        // coef write mid-MAC ignored, same write in IDLE honoured, write on accept edge honoured
        run_sample(12'h155, 0, 2, 12'h7F0, got);
        put_coef(0, 12'h7F0);
        run_sample(12'h155, 0, 0, 0, got);
        run_sample(12'h0C3, 0, 1, 12'h901, got);

        // reset in the middle of MAC
        in_valid = 1; in_data = 12'h100;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("midmac_reset", {in_ready, out_valid, busy, out_data}, {3'b100, 12'h000});
        @(posedge clk); #1;
        rst_n = 1;
        clear_model();
        all_coefs(12'h100);
        run_sample(12'h100, 0, 0, 0, got);
        chk("post_reset_impulse", got, 12'h100);
        for (int i = 1; i < 8; i++) run_sample(12'h000, 0, 0, 0, got);
        chk("post_reset_impulse_last", got, 12'h100);
        run_sample(12'h000, 0, 0, 0, got);
        chk("post_reset_impulse_tail", got, 12'h000);

        // randomized coefficients and samples
        for (int a = 0; a < 8; a++) put_coef(a, 12'($urandom_range(0, 4095)));
        for (int i = 0; i < 20; i++)
            run_sample(12'($urandom_range(0, 4095)), int'($urandom_range(0, 2)),
                       (i % 5 == 4) ? 1 : 0, 12'($urandom_range(0, 4095)), got);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
